aes_encipher_block: RTL and testbench
=====================================

Name: aes_encipher_block

Overview:
Iterative AES block encryption datapath, the forward-direction counterpart of aes_decipher_block. Supports AES-128 and AES-256.
- Accepts one 128-bit plaintext per start pulse and drives a round index to an external key memory.
- Consumes the returned round key and produces the 128-bit ciphertext after a fixed, keylen-dependent latency.
- SubBytes runs one 32-bit word per cycle through an internal S-box to bound area.

Parameters:
None. Key lengths and round counts are package constants.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- next  in  1  start pulse; sampled only while ready=1
- keylen  in  1  0=AES-128 (10 rounds), 1=AES-256 (14 rounds); sampled at start
- round  out  4  round-key index requested from key memory
- round_key  in  128  round key for index round; combinational return, same cycle
- block  in  128  plaintext; captured at start
- new_block  out  128  internal state register; ciphertext when ready=1 after a run
- ready  out  1  1=idle/done, 0=busy

Behaviour:
- Byte order: FIPS-197 column-major. Bits [127:120] are s(0,0); word w0=[127:96] … w3=[31:0].
- Reset values (asserted asynchronously, held while reset=1): ready=1, new_block=0, round=0, FSM=IDLE, word_ctr=0, round_ctr=0, latched keylen=0.
- FSM states: IDLE, INIT, SBOX, UPDATE.
- IDLE:
  - round=0.
  - next=1 captures block and keylen, clears ready, and moves to INIT.
  - next=0: stay in IDLE.
- INIT (1 cycle):
  - round=0.
  - state <= block_latched ^ round_key.
  - round_ctr <= 1, word_ctr <= 0, go to SBOX.
- SBOX (4 cycles, word_ctr 0..3):
  - round=round_ctr.
  - state word[word_ctr] <= SubWord(state word[word_ctr]) via the S-box.
  - word_ctr increments; after word 3, go to UPDATE.
- UPDATE (1 cycle):
  - round=round_ctr.
  - Round 1..Nr-1: state <= MixColumns(ShiftRows(state)) ^ round_key; round_ctr++; word_ctr <= 0; go to SBOX.
  - Final round (round_ctr=Nr): state <= ShiftRows(state) ^ round_key, with no MixColumns; ready <= 1; go to IDLE.
- Nr is 10 (keylen=0) or 14 (keylen=1).
- Latency:
  - Count from the clock edge that samples next to the edge that sets ready: 1 + 5·Nr cycles.
  - AES-128 = 51 cycles; AES-256 = 71 cycles.
  - ready and the final new_block become valid in the same cycle.
- new_block is stable from completion until the next accepted start. Intermediate values are visible while busy and are don't-care.
- next while busy: ignored. block and keylen changes while busy: no effect.
- next asserted in the first cycle ready=1 after completion: accepted; runs are back-to-back, with no idle cycle required.
- reset mid-operation: immediate abort to reset values; no partial result retained.
- round_key is consumed only in INIT and UPDATE. round is held constant through each SBOX/UPDATE group so the external memory may be registered-address/combinational-read.
- GF(2^8) arithmetic: xtime = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
- MixColumns rows per column: (2,3,1,1), (1,2,3,1), (1,1,2,3), (3,1,1,2).

Decomposition:
- Shared package aes_pkg:
  - AES_128_BIT_KEY=1'b0, AES_256_BIT_KEY=1'b1
  - AES128_ROUNDS=4'd10, AES256_ROUNDS=4'd14
  - FSM state encoding
  - functions gm2, gm3, mixw (one column), mixcolumns, shiftrows, addroundkey, shared with aes_decipher_block's inverse set
- One sub-module aes_sbox: combinational 32-bit in/out, four parallel 256-entry forward S-box byte lookups, instantiated once.

Test Plan:
- FIPS-197 C.1:
  - Stimulus: key schedule for key 000102…0f; block=00112233445566778899aabbccddeeff; keylen=0; one-cycle next.
  - Required: new_block=69c4e0d86a7b0430d8cdb78070b4c55a; ready returns exactly 51 cycles after the sampling edge; round sequence 0,1×5,2×5,…,10×5.
- FIPS-197 C.3:
  - Stimulus: 14-round key schedule for key 000102…1f; same plaintext; keylen=1.
  - Required: new_block=8ea2b7ca516745bfeafc49904b496089; latency 71 cycles; round reaches 14 and never 15.
- Busy-ignore:
  - Stimulus: pulse next again at cycle 20 of the C.1 run, with a different block and keylen=1.
  - Required: C.1 ciphertext unchanged, latency still 51 cycles, no second run starts.
- Back-to-back:
  - Stimulus: assert next in the first ready=1 cycle with block=ciphertext input of a second vector.
  - Required: first result observed for exactly one cycle, then second run completes correctly after 51 cycles.
- Reset mid-op:
  - Stimulus: assert reset asynchronously (off-edge) at cycle 30 of a run.
  - Required: ready=1, new_block=0, round=0 immediately; after release, a fresh C.1 run passes.
- Power-on:
  - Stimulus: reset only, next=0 held.
  - Required: ready=1, round=0, new_block=0 stay constant for 100 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM encoding and round-transform functions
//
// Purpose: key-length encodings, round counts, the encipher control FSM
// encoding and the forward round transforms. State words follow the FIPS-197
// column-major layout: bits [127:120] are s(0,0), w0=[127:96] ... w3=[31:0].
// Ports: none (package).
package aes_pkg;

  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS   = 4'd10;
  localparam logic [3:0] AES256_ROUNDS   = 4'd14;

  typedef enum logic [1:0] {
    CTRL_IDLE   = 2'd0,
    CTRL_INIT   = 2'd1,
    CTRL_SBOX   = 2'd2,
    CTRL_UPDATE = 2'd3
  } aes_ctrl_e;

  // xtime: multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm2(input logic [7:0] op);
    return {op[6:0], 1'b0} ^ (op[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] op);
    return gm2(op) ^ op;
  endfunction

  // One MixColumns column; rows (2,3,1,1) (1,2,3,1) (1,1,2,3) (3,1,1,2).
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
            b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] data);
    return {mixw(data[127:96]), mixw(data[95:64]), mixw(data[63:32]), mixw(data[31:0])};
  endfunction

  // Row r rotates left by r columns: s'(r,c) = s(r,(c+r) mod 4).
  function automatic logic [127:0] shiftrows(input logic [127:0] data);
    logic [31:0] w0, w1, w2, w3;
    w0 = data[127:96];
    w1 = data[95:64];
    w2 = data[63:32];
    w3 = data[31:0];
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] data,
                                               input logic [127:0] rkey);
    return data ^ rkey;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - four parallel forward AES S-box byte lookups on one 32-bit word
//
// Purpose: combinational SubWord used one state word per cycle by the encipher core.
// Ports:
//   sbox_in_i   in  32  word to substitute
//   sbox_out_o  out 32  bytewise S-box of sbox_in_i
module aes_sbox (
  input  logic [31:0] sbox_in_i,
  output logic [31:0] sbox_out_o
);

  // Entry 0 sits in the top byte, so entry x lives at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[{~x, 3'b000} +: 8];
  endfunction

  assign sbox_out_o = {sb(sbox_in_i[31:24]), sb(sbox_in_i[23:16]),
                       sb(sbox_in_i[15:8]),  sb(sbox_in_i[7:0])};

endmodule

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - iterative AES-128/256 block encryption datapath
//
// Purpose: encrypts one 128-bit block per accepted start, requesting round keys
// from an external key memory by index. SubBytes is done one word per cycle.
// Ports:
//   clk        in  1    system clock
//   reset      in  1    asynchronous active-high reset
//   next       in  1    start pulse, sampled only while ready=1
//   keylen     in  1    0=AES-128, 1=AES-256, sampled at start
//   round      out 4    round-key index presented to the key memory
//   round_key  in  128  round key for index round (same-cycle return)
//   block      in  128  plaintext, captured at start
//   new_block  out 128  state register; ciphertext once ready returns
//   ready      out 1    1=idle/done, 0=busy
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  aes_ctrl_e    state_q, state_d;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic         keylen_q, keylen_d;
  logic [127:0] block_q, block_d;
  logic         ready_q, ready_d;

  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic [3:0]   num_rounds;

  assign num_rounds = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

  always_comb begin
    sbox_in = block_q[127:96];
    case (word_ctr_q)
      2'd0: sbox_in = block_q[127:96];
      2'd1: sbox_in = block_q[95:64];
      2'd2: sbox_in = block_q[63:32];
      2'd3: sbox_in = block_q[31:0];
      default: sbox_in = block_q[127:96];
    endcase
  end

  aes_sbox u_sbox (
    .sbox_in_i  (sbox_in),
    .sbox_out_o (sbox_out)
  );

  always_comb begin
    state_d     = state_q;
    word_ctr_d  = word_ctr_q;
    round_ctr_d = round_ctr_q;
    keylen_d    = keylen_q;
    block_d     = block_q;
    ready_d     = ready_q;
    round       = 4'd0;

    case (state_q)
      CTRL_IDLE: begin
        // The plaintext is parked in the state register itself; INIT then
        // folds in round key 0 without a separate plaintext latch.
        if (next) begin
          block_d  = block;
          keylen_d = keylen;
          ready_d  = 1'b0;
          state_d  = CTRL_INIT;
        end
      end

      CTRL_INIT: begin
        block_d     = addroundkey(block_q, round_key);
        round_ctr_d = 4'd1;
        word_ctr_d  = 2'd0;
        state_d     = CTRL_SBOX;
      end

      CTRL_SBOX: begin
        // round is already the upcoming key index so the key memory address
        // stays constant across the whole SBOX/UPDATE group.
        round = round_ctr_q;
        case (word_ctr_q)
          2'd0: block_d[127:96] = sbox_out;
          2'd1: block_d[95:64]  = sbox_out;
          2'd2: block_d[63:32]  = sbox_out;
          2'd3: block_d[31:0]   = sbox_out;
          default: block_d = block_q;
        endcase
        word_ctr_d = word_ctr_q + 2'd1;
        if (word_ctr_q == 2'd3) begin
          state_d = CTRL_UPDATE;
        end
      end

      CTRL_UPDATE: begin
        round = round_ctr_q;
        if (round_ctr_q == num_rounds) begin
          block_d = addroundkey(shiftrows(block_q), round_key);
          ready_d = 1'b1;
          state_d = CTRL_IDLE;
        end else begin
          block_d     = addroundkey(mixcolumns(shiftrows(block_q)), round_key);
          round_ctr_d = round_ctr_q + 4'd1;
          word_ctr_d  = 2'd0;
          state_d     = CTRL_SBOX;
        end
      end

      default: state_d = CTRL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CTRL_IDLE;
      word_ctr_q  <= 2'd0;
      round_ctr_q <= 4'd0;
      keylen_q    <= AES_128_BIT_KEY;
      block_q     <= 128'h0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      word_ctr_q  <= word_ctr_d;
      round_ctr_q <= round_ctr_d;
      keylen_q    <= keylen_d;
      block_q     <= block_d;
      ready_q     <= ready_d;
    end
  end

  assign new_block = block_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// tb/tb_aes_encipher_block.sv - self-checking bench for aes_encipher_block
module tb_aes_encipher_block;

  logic         clk = 1'b0;
  logic         reset;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int tests = 0;
  int fails = 0;

  logic [7:0]   sb_ref [256];
  logic [127:0] rk_mem [16];

  localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  always #5 clk = ~clk;

  // Key memory model: combinational read by index.
  always_comb round_key = rk_mem[round];

  aes_encipher_block dut (
    .clk       (clk),
    .reset     (reset),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product then reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v} >> (8 - n);
    return t[7:0];
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb_ref[w[31:24]], sb_ref[w[23:16]], sb_ref[w[15:8]], sb_ref[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = kl ? 8 : 4;
    nr = kl ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk_mem[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // Byte-array cipher; byte j = 4*column + row.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic kl);
    logic [7:0] st [16];
    logic [7:0] tp [16];
    logic [127:0] res;
    int nr;
    nr = kl ? 14 : 10;
    for (int j = 0; j < 16; j++) st[j] = pt[127 - 8*j -: 8] ^ rk_mem[0][127 - 8*j -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) st[j] = sb_ref[st[j]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) tp[4*c + w] = st[4*((c + w) % 4) + w];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          if (r != nr)
            st[4*c + w] = gmul(8'h02, tp[4*c + w]) ^ gmul(8'h03, tp[4*c + (w+1)%4])
                        ^ tp[4*c + (w+2)%4] ^ tp[4*c + (w+3)%4];
          else
            st[4*c + w] = tp[4*c + w];
      for (int j = 0; j < 16; j++) st[j] = st[j] ^ rk_mem[r][127 - 8*j -: 8];
    end
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = st[j];
    return res;
  endfunction

  // Called at posedge+1 with ready=1; returns at posedge+1 of the first ready cycle.
  task automatic run_op(input string tag, input logic [127:0] pt, input logic kl,
                        input int poke_cyc, input logic [127:0] exp_ct);
    int nr, cyc, rerr, maxr, exp_r;
    nr = kl ? 14 : 10;
    block = pt; keylen = kl; next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    block = {$urandom, $urandom, $urandom, $urandom};
    keylen = ~kl;
    chk({tag, "_busy"}, 128'(ready), 128'(0));
    cyc = 0;
    rerr = (round !== 4'd0) ? 1 : 0;
    maxr = 0;
    while (ready !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      next = 1'b0;
      if (cyc == poke_cyc) begin
        next = 1'b1;
        block = {$urandom, $urandom, $urandom, $urandom};
        keylen = 1'b1;
      end
      if (ready !== 1'b1) begin
        exp_r = (cyc - 1) / 5 + 1;
        if (round !== 4'(exp_r)) rerr++;
        if (int'(round) > maxr) maxr = int'(round);
      end
    end
    next = 1'b0;
    chk({tag, "_latency"}, 128'(cyc), 128'(1 + 5*nr));
    chk({tag, "_round_seq_errs"}, 128'(rerr), 128'(0));
    chk({tag, "_max_round"}, 128'(maxr), 128'(nr));
    chk({tag, "_ct"}, new_block, exp_ct);
  endtask

  initial begin
    logic [127:0] ct1, pt2, pt;
    logic [255:0] key;
    logic         kl;
    int           errs;

    reset = 1'b1; next = 1'b0; keylen = 1'b0; block = '0;
    for (int r = 0; r < 16; r++) rk_mem[r] = '0;
    build_sbox();

    // Power-on: reset held, then 100 idle cycles with next=0.
    repeat (3) @(posedge clk);
    #1;
    chk("por_ready", 128'(ready), 128'(1));
    chk("por_round", 128'(round), 128'(0));
    chk("por_block", new_block, 128'h0);
    reset = 1'b0;
    errs = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ready !== 1'b1 || round !== 4'd0 || new_block !== 128'h0) errs++;
    end
    chk("idle_100_errs", 128'(errs), 128'(0));

    // FIPS-197 C.1 and C.3.
    expand_key(K128, 1'b0);
    run_op("c1", C_PT, 1'b0, 0, C1_CT);
    expand_key(K256, 1'b1);
    run_op("c3", C_PT, 1'b1, 0, C3_CT);

    // Busy-ignore: second start at cycle 20 must not disturb the run.
    expand_key(K128, 1'b0);
    run_op("c1_poke", C_PT, 1'b0, 20, C1_CT);
    repeat (3) @(posedge clk);
    #1;
    chk("poke_no_rerun_ready", 128'(ready), 128'(1));
    chk("poke_no_rerun_ct", new_block, C1_CT);

    // Back-to-back: C.1 then immediately encrypt its ciphertext.
    run_op("b2b_first", C_PT, 1'b0, 0, C1_CT);
    ct1 = C1_CT;
    pt2 = ct1;
    run_op("b2b_second", pt2, 1'b0, 0, aes_ref(pt2, 1'b0));

    // Reset mid-operation, applied away from the clock edge.
    block = C_PT; keylen = 1'b0; next = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 128'(ready), 128'(1));
    chk("midrst_block", new_block, 128'h0);
    chk("midrst_round", 128'(round), 128'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    run_op("c1_after_reset", C_PT, 1'b0, 0, C1_CT);

    // Random keys, key lengths and plaintexts against the byte-level model.
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      kl  = 1'($urandom_range(0, 1));
      pt  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, kl);
      run_op($sformatf("rand%0d", n), pt, kl, 0, aes_ref(pt, kl));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
